// File: rtl/pipe_add_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Op-control bundle travels alongside each beat down the pipe.
package pipe_add_pkg;

  function automatic int slice_w(input int n, input int stages);
    return n / stages;
  endfunction

  typedef struct packed {
    logic sub;
    logic enable;
    logic sat;
  } op_ctrl_t;

endpackage

// File: rtl/pipe_add_slice.sv
// W-bit adder slice, registered sum and carry-out, 1-cycle latency.
// hold=1 freezes both registers so the pipe can stall in place.
module pipe_add_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum_q,
  output logic         carry_q
);

  logic [W-1:0] sum_d;
  logic         carry_d;

  always_comb begin
    {carry_d, sum_d} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
    if (hold) begin
      sum_d   = sum_q;
      carry_d = carry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined N-bit add/sub in STAGES carry slices; STAGES-cycle latency, 1 beat/cycle; whole pipe
// stalls while the output beat waits (in_ready = !out_valid || out_ready). PIPE_ADD_SAT_EN adds sat.
module pipe_add_sub
  import pipe_add_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  input  logic         enable,
`ifdef PIPE_ADD_SAT_EN
  input  logic         sat,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int W = slice_w(N, STAGES);

  logic         advance;
  logic [N-1:0] a_eff, b_eff;
  logic         c_eff;
  op_ctrl_t     ctl_in;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] msb_a_q, msb_a_d, msb_b_q, msb_b_d;
  op_ctrl_t          ctl_q   [STAGES];
  op_ctrl_t          ctl_d   [STAGES];
  logic [N-1:0]      a_rem_q [STAGES];
  logic [N-1:0]      a_rem_d [STAGES];
  logic [N-1:0]      b_rem_q [STAGES];
  logic [N-1:0]      b_rem_d [STAGES];
  logic [N-1:0]      res_q   [STAGES];
  logic [N-1:0]      res_d   [STAGES];

  logic [W-1:0]      sl_a    [STAGES];
  logic [W-1:0]      sl_b    [STAGES];
  logic [W-1:0]      sl_sum  [STAGES];
  logic [STAGES-1:0] sl_cin, sl_cout;

  logic [N-1:0] s_raw, s_out;
  logic         ovf_raw;
  logic         unused_tail;

  // Drop a finished W-bit sum slice into its lane of an N-bit word.
  function automatic logic [N-1:0] place(input logic [W-1:0] v, input int k);
    logic [N-1:0] ext;
    ext        = '0;
    ext[W-1:0] = v;
    return ext << (k * W);
  endfunction

  assign out_valid = vld_q[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  always_comb begin
    ctl_in        = '0;
    ctl_in.sub    = sub;
    ctl_in.enable = enable;
`ifdef PIPE_ADD_SAT_EN
    ctl_in.sat    = sat;
`endif
    a_eff = enable ? a : '0;
    b_eff = enable ? (sub ? ~b : b) : '0;
    c_eff = enable & (sub | cin);
  end

  // Slice 0 adds straight from the ports; later slices take the skewed operand remnants.
  always_comb begin
    sl_a[0]   = a_eff[W-1:0];
    sl_b[0]   = b_eff[W-1:0];
    sl_cin[0] = c_eff;
    for (int j = 1; j < STAGES; j++) begin
      sl_a[j]   = a_rem_q[j-1][W-1:0];
      sl_b[j]   = b_rem_q[j-1][W-1:0];
      sl_cin[j] = sl_cout[j-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    pipe_add_slice #(.W(W)) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold    (!advance),
      .a       (sl_a[k]),
      .b       (sl_b[k]),
      .c_in    (sl_cin[k]),
      .sum_q   (sl_sum[k]),
      .carry_q (sl_cout[k])
    );
  end

  always_comb begin
    vld_d   = vld_q;
    msb_a_d = msb_a_q;
    msb_b_d = msb_b_q;
    ctl_d   = ctl_q;
    a_rem_d = a_rem_q;
    b_rem_d = b_rem_q;
    res_d   = res_q;
    if (advance) begin
      vld_d[0]   = in_valid;
      msb_a_d[0] = a_eff[N-1];
      msb_b_d[0] = b_eff[N-1];
      ctl_d[0]   = ctl_in;
      a_rem_d[0] = a_eff >> W;
      b_rem_d[0] = b_eff >> W;
      res_d[0]   = '0;
      for (int j = 1; j < STAGES; j++) begin
        vld_d[j]   = vld_q[j-1];
        msb_a_d[j] = msb_a_q[j-1];
        msb_b_d[j] = msb_b_q[j-1];
        ctl_d[j]   = ctl_q[j-1];
        a_rem_d[j] = a_rem_q[j-1] >> W;
        b_rem_d[j] = b_rem_q[j-1] >> W;
        res_d[j]   = res_q[j-1] | place(sl_sum[j-1], j - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      msb_a_q <= '0;
      msb_b_q <= '0;
      for (int j = 0; j < STAGES; j++) begin
        ctl_q[j]   <= '0;
        a_rem_q[j] <= '0;
        b_rem_q[j] <= '0;
        res_q[j]   <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      msb_a_q <= msb_a_d;
      msb_b_q <= msb_b_d;
      ctl_q   <= ctl_d;
      a_rem_q <= a_rem_d;
      b_rem_q <= b_rem_d;
      res_q   <= res_d;
    end
  end

  assign s_raw   = res_q[STAGES-1] | place(sl_sum[STAGES-1], STAGES - 1);
  assign ovf_raw = (msb_a_q[STAGES-1] == msb_b_q[STAGES-1]) &&
                   (s_raw[N-1] != msb_a_q[STAGES-1]);

  always_comb begin
    s_out = s_raw;
`ifdef PIPE_ADD_SAT_EN
    // Overflow direction follows operand A's sign: negative A can only underflow.
    if (ctl_q[STAGES-1].sat && ovf_raw) begin
      s_out = msb_a_q[STAGES-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`endif
  end

  assign s    = s_out;
  assign cout = sl_cout[STAGES-1];
  assign ovf  = ovf_raw;
  assign zero = out_valid && (s_out == '0);

  // Last-stage remnants are always shifted-out zeros; ctl fields beyond sat ride along unread.
  assign unused_tail = ^{a_rem_q[STAGES-1], b_rem_q[STAGES-1], ctl_q[STAGES-1]};

endmodule
